// File: rtl/riscv_cpu_pkg.sv
// ----------------------------------------------------------------------------
// riscv_cpu_pkg
// Shared types and constants for the execute stage:
//   alu_op_e   - operation encoding driven by decode
//   ex_state_e - execute-stage sequencing states (IDLE / MUL / DONE)
//   CSR_*      - bit positions of the condition flags {ovf, carry, neg, zero}
//   make_flags - packs individual flags into the CSR vector
// ----------------------------------------------------------------------------
package riscv_cpu_pkg;

    typedef enum logic [3:0] {
        ALU_ADD  = 4'd0,
        ALU_SUB  = 4'd1,
        ALU_AND  = 4'd2,
        ALU_OR   = 4'd3,
        ALU_XOR  = 4'd4,
        ALU_SLL  = 4'd5,
        ALU_SRL  = 4'd6,
        ALU_SRA  = 4'd7,
        ALU_SLT  = 4'd8,
        ALU_SLTU = 4'd9,
        ALU_MUL  = 4'd10
    } alu_op_e;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        MUL  = 2'd1,
        DONE = 2'd2
    } ex_state_e;

    localparam int CSR_ZERO  = 0;
    localparam int CSR_NEG   = 1;
    localparam int CSR_CARRY = 2;
    localparam int CSR_OVF   = 3;

    function automatic logic [3:0] make_flags(input logic ovf, input logic carry,
                                              input logic neg, input logic zero);
        logic [3:0] f;
        f            = '0;
        f[CSR_ZERO]  = zero;
        f[CSR_NEG]   = neg;
        f[CSR_CARRY] = carry;
        f[CSR_OVF]   = ovf;
        return f;
    endfunction

endpackage

// File: rtl/alu.sv
// ----------------------------------------------------------------------------
// alu
// Shared single-cycle, purely combinational ALU.
// Ports:
//   op_i     - operation (alu_op_e); MUL and undefined codes give result 0
//   a_i, b_i - operands, DATA_WIDTH bits
//   result_o - result, DATA_WIDTH bits
//   csr_o    - flags {ovf, carry, neg, zero}; carry/ovf only meaningful for ADD/SUB
// ----------------------------------------------------------------------------
module alu
    import riscv_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32
) (
    input  alu_op_e               op_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic [DATA_WIDTH-1:0] result_o,
    output logic [3:0]            csr_o
);

    localparam int SH_W = $clog2(DATA_WIDTH);
    localparam int MSB  = DATA_WIDTH - 1;

    logic        [SH_W-1:0]       shamt;
    logic        [DATA_WIDTH:0]   sum;
    logic        [DATA_WIDTH:0]   diff;
    logic signed [DATA_WIDTH-1:0] a_s;
    logic signed [DATA_WIDTH-1:0] b_s;
    logic                         carry;
    logic                         ovf;

    always_comb begin
        shamt    = b_i[SH_W-1:0];
        a_s      = a_i;
        b_s      = b_i;
        sum      = {1'b0, a_i} + {1'b0, b_i};
        // Extra bit of the subtraction is the borrow, reported as carry for SUB.
        diff     = {1'b0, a_i} - {1'b0, b_i};
        result_o = '0;
        carry    = 1'b0;
        ovf      = 1'b0;
        case (op_i)
            ALU_ADD: begin
                result_o = sum[DATA_WIDTH-1:0];
                carry    = sum[DATA_WIDTH];
                ovf      = (a_i[MSB] == b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            end
            ALU_SUB: begin
                result_o = diff[DATA_WIDTH-1:0];
                carry    = diff[DATA_WIDTH];
                ovf      = (a_i[MSB] != b_i[MSB]) && (result_o[MSB] != a_i[MSB]);
            end
            ALU_AND:  result_o = a_i & b_i;
            ALU_OR:   result_o = a_i | b_i;
            ALU_XOR:  result_o = a_i ^ b_i;
            ALU_SLL:  result_o = a_i << shamt;
            ALU_SRL:  result_o = a_i >> shamt;
            ALU_SRA:  result_o = a_s >>> shamt;
            ALU_SLT:  result_o = {{(DATA_WIDTH-1){1'b0}}, (a_s < b_s)};
            ALU_SLTU: result_o = {{(DATA_WIDTH-1){1'b0}}, (a_i < b_i)};
            default:  result_o = '0;
        endcase
        csr_o = make_flags(ovf, carry, result_o[MSB], (result_o == '0));
    end

endmodule

// File: rtl/mul_iter.sv
// ----------------------------------------------------------------------------
// mul_iter
// Iterative shift-add multiplier, one partial product per cycle, DATA_WIDTH
// steps. Produces the low DATA_WIDTH bits of the unsigned product.
// Ports:
//   clk_i, rst_i - clock, synchronous active-high reset
//   abort_i      - stop an in-progress multiply
//   start_i      - latch a_i/b_i, clear the accumulator, begin stepping
//   a_i, b_i     - operands
//   done_o       - high during the final step; product_o is final the cycle after
//   product_o    - accumulator (low DATA_WIDTH bits of a*b once finished)
// ----------------------------------------------------------------------------
module mul_iter #(
    parameter int DATA_WIDTH = 32
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  abort_i,
    input  logic                  start_i,
    input  logic [DATA_WIDTH-1:0] a_i,
    input  logic [DATA_WIDTH-1:0] b_i,
    output logic                  done_o,
    output logic [DATA_WIDTH-1:0] product_o
);

    localparam int CNT_W = $clog2(DATA_WIDTH);

    logic [DATA_WIDTH-1:0] mcand_q;
    logic [DATA_WIDTH-1:0] mplier_q;
    logic [DATA_WIDTH-1:0] acc_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  run_q;

    assign done_o    = run_q && (cnt_q == CNT_W'(DATA_WIDTH - 1));
    assign product_o = acc_q;

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            run_q    <= 1'b0;
            cnt_q    <= '0;
            acc_q    <= '0;
            mcand_q  <= '0;
            mplier_q <= '0;
        end else if (abort_i) begin
            run_q <= 1'b0;
            cnt_q <= '0;
        end else if (start_i) begin
            mcand_q  <= a_i;
            mplier_q <= b_i;
            acc_q    <= '0;
            cnt_q    <= '0;
            run_q    <= 1'b1;
        end else if (run_q) begin
            // Bits shifted past the top of mcand only affect the discarded high half.
            if (mplier_q[0]) begin
                acc_q <= acc_q + mcand_q;
            end
            mcand_q  <= mcand_q << 1;
            mplier_q <= mplier_q >> 1;
            cnt_q    <= cnt_q + 1'b1;
            if (done_o) begin
                run_q <= 1'b0;
            end
        end
    end

endmodule

// File: rtl/ex_stage_hs.sv
// ----------------------------------------------------------------------------
// ex_stage_hs
// Elastic execute stage between decode and memory. Accepts one op per cycle
// over valid/ready, evaluates single-cycle ALU ops, optionally runs an
// iterative multiply, and holds the result plus pipeline sidecar in an output
// register with back-pressure and flush.
//
// Build option: define EX_MUL_EN to build the iterative multiplier and the
// MUL/DONE sequencing. Without it ALU_MUL completes in one cycle with result 0
// and busy_o is tied low.
//
// Ports:
//   clk_i, rst_i                       clock, synchronous active-high reset
//   in_valid_i / in_ready_o            upstream handshake
//   flush_i                            drop the buffered result and any multiply
//   pc_i, instr_rdata_i, branch_addr_i sidecar in (32 bits each)
//   data_a_i, data_b_i, alu_op_i       operands and operation
//   branch_mux_i                       sidecar in (2 bits)
//   out_valid_o / out_ready_i          downstream handshake
//   pc_o, instr_rdata_o, branch_addr_o registered sidecar
//   data_a_o, data_b_o, alu_result_o   registered operands and result
//   csr_o                              registered flags {ovf, carry, neg, zero}
//   branch_mux_o                       registered sidecar
//   busy_o                             multiply in progress
// ----------------------------------------------------------------------------
module ex_stage_hs
    import riscv_cpu_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int CSR_WIDTH  = 4
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  in_valid_i,
    output logic                  in_ready_o,
    input  logic                  flush_i,
    input  logic [31:0]           pc_i,
    input  logic [31:0]           instr_rdata_i,
    input  logic [31:0]           branch_addr_i,
    input  logic [DATA_WIDTH-1:0] data_a_i,
    input  logic [DATA_WIDTH-1:0] data_b_i,
    input  alu_op_e               alu_op_i,
    input  logic [1:0]            branch_mux_i,
    output logic                  out_valid_o,
    input  logic                  out_ready_i,
    output logic [31:0]           pc_o,
    output logic [31:0]           instr_rdata_o,
    output logic [31:0]           branch_addr_o,
    output logic [DATA_WIDTH-1:0] data_a_o,
    output logic [DATA_WIDTH-1:0] data_b_o,
    output logic [DATA_WIDTH-1:0] alu_result_o,
    output logic [CSR_WIDTH-1:0]  csr_o,
    output logic [1:0]            branch_mux_o,
    output logic                  busy_o
);

    // Output register
    logic                  out_valid_q;
    logic [31:0]           pc_q, instr_q, baddr_q;
    logic [DATA_WIDTH-1:0] a_q, b_q, res_q;
    logic [CSR_WIDTH-1:0]  csr_q;
    logic [1:0]            bmux_q;

    // Next values for the output register
    logic [31:0]           pc_d, instr_d, baddr_d;
    logic [DATA_WIDTH-1:0] a_d, b_d, res_d;
    logic [CSR_WIDTH-1:0]  csr_d;
    logic [1:0]            bmux_d;

    logic [DATA_WIDTH-1:0] alu_res;
    logic [3:0]            alu_csr;
    logic                  out_free;
    logic                  idle;
    logic                  is_mul;
    logic                  accept;
    logic                  load_alu;
    logic                  load_mul;
    logic                  load;

    alu #(.DATA_WIDTH(DATA_WIDTH)) u_alu (
        .op_i     (alu_op_i),
        .a_i      (data_a_i),
        .b_i      (data_b_i),
        .result_o (alu_res),
        .csr_o    (alu_csr)
    );

    // The output slot can take a new value if empty or being drained this edge.
    assign out_free   = !out_valid_q || out_ready_i;
    assign in_ready_o = !rst_i && !flush_i && idle && out_free;
    assign accept     = in_valid_i && in_ready_o;
    assign load_alu   = accept && !is_mul;
    assign load       = load_alu || load_mul;

`ifdef EX_MUL_EN
    ex_state_e             state_q;
    logic [31:0]           h_pc_q, h_instr_q, h_baddr_q;
    logic [DATA_WIDTH-1:0] h_a_q, h_b_q;
    logic [1:0]            h_bmux_q;
    logic                  mul_start;
    logic                  mul_done;
    logic [DATA_WIDTH-1:0] mul_prod;

    assign idle      = (state_q == IDLE);
    assign is_mul    = (alu_op_i == ALU_MUL);
    assign mul_start = accept && is_mul;
    assign load_mul  = (state_q == DONE) && out_free;
    assign busy_o    = (state_q != IDLE);

    mul_iter #(.DATA_WIDTH(DATA_WIDTH)) u_mul (
        .clk_i     (clk_i),
        .rst_i     (rst_i),
        .abort_i   (flush_i),
        .start_i   (mul_start),
        .a_i       (data_a_i),
        .b_i       (data_b_i),
        .done_o    (mul_done),
        .product_o (mul_prod)
    );

    // Sequencing FSM; the sidecar of a multiply is held here until DONE.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            state_q   <= IDLE;
            h_pc_q    <= '0;
            h_instr_q <= '0;
            h_baddr_q <= '0;
            h_a_q     <= '0;
            h_b_q     <= '0;
            h_bmux_q  <= '0;
        end else if (flush_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: begin
                    if (mul_start) begin
                        state_q   <= MUL;
                        h_pc_q    <= pc_i;
                        h_instr_q <= instr_rdata_i;
                        h_baddr_q <= branch_addr_i;
                        h_a_q     <= data_a_i;
                        h_b_q     <= data_b_i;
                        h_bmux_q  <= branch_mux_i;
                    end
                end
                MUL: begin
                    if (mul_done) begin
                        state_q <= DONE;
                    end
                end
                DONE: begin
                    if (out_free) begin
                        state_q <= IDLE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end
`else
    assign idle     = 1'b1;
    assign is_mul   = 1'b0;
    assign load_mul = 1'b0;
    assign busy_o   = 1'b0;
`endif

    always_comb begin
        pc_d    = pc_i;
        instr_d = instr_rdata_i;
        baddr_d = branch_addr_i;
        a_d     = data_a_i;
        b_d     = data_b_i;
        bmux_d  = branch_mux_i;
        res_d   = alu_res;
        csr_d   = alu_csr;
`ifdef EX_MUL_EN
        if (state_q == DONE) begin
            pc_d    = h_pc_q;
            instr_d = h_instr_q;
            baddr_d = h_baddr_q;
            a_d     = h_a_q;
            b_d     = h_b_q;
            bmux_d  = h_bmux_q;
            res_d   = mul_prod;
            csr_d   = make_flags(1'b0, 1'b0, mul_prod[DATA_WIDTH-1], (mul_prod == '0));
        end
`endif
    end

    // Flush beats any load; a simultaneous drain and load keeps out_valid high.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            out_valid_q <= 1'b0;
            pc_q        <= '0;
            instr_q     <= '0;
            baddr_q     <= '0;
            a_q         <= '0;
            b_q         <= '0;
            res_q       <= '0;
            csr_q       <= '0;
            bmux_q      <= '0;
        end else if (flush_i) begin
            out_valid_q <= 1'b0;
        end else if (load) begin
            out_valid_q <= 1'b1;
            pc_q        <= pc_d;
            instr_q     <= instr_d;
            baddr_q     <= baddr_d;
            a_q         <= a_d;
            b_q         <= b_d;
            res_q       <= res_d;
            csr_q       <= csr_d;
            bmux_q      <= bmux_d;
        end else if (out_ready_i) begin
            out_valid_q <= 1'b0;
        end
    end

    assign out_valid_o   = out_valid_q;
    assign pc_o          = pc_q;
    assign instr_rdata_o = instr_q;
    assign branch_addr_o = baddr_q;
    assign data_a_o      = a_q;
    assign data_b_o      = b_q;
    assign alu_result_o  = res_q;
    assign csr_o         = csr_q;
    assign branch_mux_o  = bmux_q;

endmodule

// File: tb/tb_ex_stage_hs.sv
// ----------------------------------------------------------------------------
// tb_ex_stage_hs
// Scoreboard bench for ex_stage_hs: the driver pushes the expected result of
// every op that should reach the output; an independent monitor pops and
// compares whenever a result is handed downstream. Directed checks cover
// reset, back-pressure, flush and multiply timing. EX_MUL_EN selects which
// multiply behaviour is expected.
// ----------------------------------------------------------------------------
module tb_ex_stage_hs;
    import riscv_cpu_pkg::*;

    localparam int W = 32;

    logic          clk = 1'b0;
    logic          rst;
    logic          in_valid, in_ready, flush;
    logic [31:0]   pc_in, instr_in, baddr_in;
    logic [W-1:0]  da, db;
    alu_op_e       op;
    logic [1:0]    bmux_in;
    logic          out_valid, out_ready;
    logic [31:0]   pc_out, instr_out, baddr_out;
    logic [W-1:0]  da_out, db_out, res_out;
    logic [3:0]    csr_out;
    logic [1:0]    bmux_out;
    logic          busy;

    ex_stage_hs #(.DATA_WIDTH(W), .CSR_WIDTH(4)) dut (
        .clk_i         (clk),
        .rst_i         (rst),
        .in_valid_i    (in_valid),
        .in_ready_o    (in_ready),
        .flush_i       (flush),
        .pc_i          (pc_in),
        .instr_rdata_i (instr_in),
        .branch_addr_i (baddr_in),
        .data_a_i      (da),
        .data_b_i      (db),
        .alu_op_i      (op),
        .branch_mux_i  (bmux_in),
        .out_valid_o   (out_valid),
        .out_ready_i   (out_ready),
        .pc_o          (pc_out),
        .instr_rdata_o (instr_out),
        .branch_addr_o (baddr_out),
        .data_a_o      (da_out),
        .data_b_o      (db_out),
        .alu_result_o  (res_out),
        .csr_o         (csr_out),
        .branch_mux_o  (bmux_out),
        .busy_o        (busy)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [W-1:0] res;
        logic [3:0]   csr;
        logic [31:0]  pc;
        logic [W-1:0] a;
    } exp_t;

    exp_t q[$];
    exp_t mon_e;
    int   n_checks = 0;
    int   n_fail   = 0;
    int   cyc      = 0;
    bit   busy_seen = 1'b0;

    always @(posedge clk) cyc++;
    always @(negedge clk) if (busy === 1'b1) busy_seen = 1'b1;

    task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // Monitor: a result transfers on the next rising edge when valid && ready.
    always @(negedge clk) begin
        #1;
        if (rst === 1'b0 && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_output: got result %0h with empty scoreboard", res_out);
            end else begin
                mon_e = q.pop_front();
                check("result_flags", {csr_out, res_out}, {mon_e.csr, mon_e.res});
                check("sidecar_pc_instr", {pc_out, instr_out},
                      {mon_e.pc, mon_e.pc ^ 32'hA5A5_0000});
                check("sidecar_baddr_a_mux", {baddr_out, da_out, bmux_out},
                      {mon_e.pc + 32'd4, mon_e.a, mon_e.pc[1:0]});
            end
        end
    end

    // Called just after a falling edge; returns just after the next falling edge
    // following acceptance, with in_valid dropped.
    task automatic send(input alu_op_e o, input logic [W-1:0] a, input logic [W-1:0] b,
                        input logic [31:0] pc, input bit push,
                        input logic [W-1:0] res, input logic [3:0] csr);
        exp_t e;
        int   guard;
        if (push) begin
            e.res = res; e.csr = csr; e.pc = pc; e.a = a;
            q.push_back(e);
        end
        in_valid = 1'b1; op = o; da = a; db = b;
        pc_in = pc; instr_in = pc ^ 32'hA5A5_0000; baddr_in = pc + 32'd4; bmux_in = pc[1:0];
        guard = 0;
        #1;
        while (in_ready !== 1'b1 && guard < 60) begin
            @(negedge clk);
            #1;
            guard++;
        end
        check("accept", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    initial begin
        #300000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int t0;
        int cnt;
        bit ready_bad;

        rst = 1'b1; in_valid = 1'b0; flush = 1'b0; out_ready = 1'b0;
        op = ALU_ADD; da = '0; db = '0; pc_in = '0; instr_in = '0; baddr_in = '0; bmux_in = '0;

        // Reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        #1;
        check("rst_out_valid", out_valid, 1'b0);
        check("rst_in_ready", in_ready, 1'b0);
        check("rst_result_csr", {csr_out, res_out}, '0);
        check("rst_sidecar", {pc_out, instr_out, baddr_out, bmux_out}, '0);
        check("rst_busy", busy, 1'b0);
        @(negedge clk);
        rst = 1'b0;
        out_ready = 1'b1;
        #1;
        check("post_rst_in_ready", in_ready, 1'b1);

        // Full-throughput stream
        @(negedge clk);
        t0 = cyc;
        send(ALU_ADD, 32'd5,    32'd7,    32'h100, 1, 32'd12,        4'b0000);
        send(ALU_SUB, 32'd3,    32'd5,    32'h104, 1, 32'hFFFF_FFFE, 4'b0110);
        send(ALU_XOR, 32'hF0,   32'hFF,   32'h108, 1, 32'h0F,        4'b0000);
        check("stream_cycles", cyc - t0, 3);

        // Remaining ops and boundaries
        send(ALU_AND,  32'hF0F0,      32'hFF00,      32'h10C, 1, 32'hF000,      4'b0000);
        send(ALU_OR,   32'h0,         32'h0,         32'h110, 1, 32'h0,         4'b0001);
        send(ALU_SLL,  32'h1,         32'd31,        32'h114, 1, 32'h8000_0000, 4'b0010);
        send(ALU_SLL,  32'h1,         32'd33,        32'h118, 1, 32'h2,         4'b0000);
        send(ALU_SRL,  32'h8000_0000, 32'd4,         32'h11C, 1, 32'h0800_0000, 4'b0000);
        send(ALU_SRA,  32'h8000_0000, 32'd4,         32'h120, 1, 32'hF800_0000, 4'b0010);
        send(ALU_SLT,  32'hFFFF_FFFF, 32'd1,         32'h124, 1, 32'h1,         4'b0000);
        send(ALU_SLTU, 32'hFFFF_FFFF, 32'd1,         32'h128, 1, 32'h0,         4'b0001);
        send(ALU_ADD,  32'h7FFF_FFFF, 32'd1,         32'h12C, 1, 32'h8000_0000, 4'b1010);
        send(ALU_ADD,  32'hFFFF_FFFF, 32'd1,         32'h130, 1, 32'h0,         4'b0101);
        send(ALU_SUB,  32'h8000_0000, 32'd1,         32'h134, 1, 32'h7FFF_FFFF, 4'b1000);
        send(alu_op_e'(4'hF), 32'h1234, 32'h5678,    32'h138, 1, 32'h0,         4'b0001);

        // Back-pressure: drain first, then block the output
        @(negedge clk);
        out_ready = 1'b0;
        send(ALU_ADD, 32'd1, 32'd1, 32'h200, 1, 32'd2, 4'b0000);
        q.push_back('{res: 32'd7, csr: 4'b0000, pc: 32'h204, a: 32'd10});
        in_valid = 1'b1; op = ALU_SUB; da = 32'd10; db = 32'd3;
        pc_in = 32'h204; instr_in = 32'h204 ^ 32'hA5A5_0000; baddr_in = 32'h208; bmux_in = 2'b00;
        repeat (3) begin
            #1;
            check("bp_hold", {out_valid, in_ready, res_out}, {1'b1, 1'b0, 32'd2});
            @(negedge clk);
        end
        out_ready = 1'b1;
        #1;
        check("bp_release_ready", in_ready, 1'b1);
        @(posedge clk);
        @(negedge clk);
        in_valid = 1'b0;
        #1;
        check("bp_next_result", {out_valid, res_out}, {1'b1, 32'd7});

        // Flush a buffered result; an op offered during flush must be ignored
        @(negedge clk);
        out_ready = 1'b0;
        send(ALU_ADD, 32'd2, 32'd2, 32'h300, 0, '0, '0);
        flush = 1'b1;
        in_valid = 1'b1; op = ALU_ADD; da = 32'd9; db = 32'd9; pc_in = 32'h304;
        #1;
        check("flush_in_ready", in_ready, 1'b0);
        @(negedge clk);
        flush = 1'b0;
        in_valid = 1'b0;
        #1;
        check("flush_clears", {out_valid, in_ready}, {1'b0, 1'b1});
        @(negedge clk);
        out_ready = 1'b1;
        send(ALU_ADD, 32'd3, 32'd4, 32'h308, 1, 32'd7, 4'b0000);

`ifdef EX_MUL_EN
        // Multiply: busy for DATA_WIDTH+1 cycles, result lands as busy drops
        send(ALU_MUL, 32'd6, 32'd7, 32'h400, 1, 32'd42, 4'b0000);
        cnt = 0;
        ready_bad = 1'b0;
        #1;
        while (busy === 1'b1 && cnt < 100) begin
            if (in_ready !== 1'b0) ready_bad = 1'b1;
            cnt++;
            @(negedge clk);
            #1;
        end
        check("mul_busy_cycles", cnt, W + 1);
        check("mul_in_ready_low", ready_bad, 1'b0);
        check("mul_out_valid", out_valid, 1'b1);
        @(negedge clk);

        send(ALU_MUL, 32'h1_0000, 32'h1_0000, 32'h404, 1, 32'h0, 4'b0001);
        cnt = 0;
        #1;
        while (busy === 1'b1 && cnt < 100) begin
            cnt++;
            @(negedge clk);
            #1;
        end
        check("mul_wrap_cycles", cnt, W + 1);
        @(negedge clk);

        // Abort a multiply part way through
        send(ALU_MUL, 32'd3, 32'd3, 32'h408, 0, '0, '0);
        repeat (8) @(negedge clk);
        flush = 1'b1;
        @(negedge clk);
        flush = 1'b0;
        #1;
        check("mul_flush_idle", {busy, in_ready, out_valid}, {1'b0, 1'b1, 1'b0});
        @(negedge clk);
        send(ALU_ADD, 32'd20, 32'd22, 32'h40C, 1, 32'd42, 4'b0000);
`else
        // No multiplier: MUL behaves as a one-cycle op yielding 0
        t0 = cyc;
        send(ALU_MUL, 32'd6, 32'd7, 32'h400, 1, 32'h0, 4'b0001);
        #1;
        check("mul_off_one_cycle", {out_valid, res_out, csr_out}, {1'b1, 32'h0, 4'b0001});
        check("mul_off_latency", cyc - t0, 1);
`endif

        // Drain and confirm every expected result was delivered
        @(negedge clk);
        out_ready = 1'b1;
        repeat (4) @(negedge clk);
        #2;
`ifndef EX_MUL_EN
        check("busy_never", busy_seen, 1'b0);
`endif
        check("scoreboard_empty", q.size(), 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
